mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one sequential multiplier datapath (start / multiplier / multiplicand in; done / sign / product out) between NREQ requesters.
- Round-robin arbitration; latches the winner's operands; sequences the multiplier with a single start pulse and waits for done.
- Returns sign/product to the winner only, with a one-cycle response strobe.
- Sits between the client blocks and the multiplier top level.

Parameters:
- DW, 4, operand width (multiplier, multiplicand)
- DW_2, 8, product width (2*DW)
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 64, cycles to wait for mult_done before abort (used only with the optional feature)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req  in  NREQ  per-requester request level
- req_multiplier  in  NREQ*DW  packed operands; slice i belongs to requester i
- req_multiplicand  in  NREQ*DW  packed operands; slice i belongs to requester i
- gnt  out  NREQ  one-hot, one-cycle grant pulse; marks operand capture
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe
- rsp_sign  out  1  result sign, shared bus
- rsp_product  out  DW_2  result magnitude, shared bus
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- mult_start  out  1  start pulse to the multiplier
- mult_multiplier  out  DW  operand to the multiplier
- mult_multiplicand  out  DW  operand to the multiplier
- mult_done  in  1  completion from the multiplier
- mult_sign  in  1  result sign from the multiplier
- mult_product  in  DW_2  result magnitude from the multiplier

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, all outputs 0.
  - Applies mid-operation too: any in-flight operation is dropped and no rsp_valid is issued.
- All outputs are registered.
- FSM states: IDLE, RUN, WAIT, RESP.
- IDLE:
  - If req≠0, select the first set bit scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - At that edge: latch idx and the idx operand slices into mult_multiplier/mult_multiplicand; gnt[idx]<=1; mult_start<=1; go RUN.
  - If req=0, stay in IDLE.
- RUN (exactly 1 cycle):
  - gnt and mult_start are high during this cycle; both drop at the next edge.
  - mult_done is ignored in this cycle.
  - Go WAIT.
- WAIT:
  - On mult_done=1: capture mult_sign/mult_product into rsp_sign/rsp_product; rsp_valid[idx]<=1; rsp_err<=0; go RESP.
- RESP (exactly 1 cycle):
  - rsp_valid[idx] is high during this cycle.
  - At the next edge: rr_ptr<=(idx+1) mod NREQ; go IDLE.
- Hold rules:
  - mult_multiplier/mult_multiplicand stay constant from the grant edge until the next grant.
  - rsp_sign/rsp_product/rsp_err hold their value until the next response.
- Latency:
  - req sampled in IDLE at edge k → gnt and mult_start high in cycle k+1.
  - mult_done seen at edge m → rsp_valid high in cycle m+1.
  - Minimum back-to-back request-to-grant spacing: 1 idle cycle after RESP.
- Requester protocol:
  - Requester i holds req[i] and its operands stable until gnt[i].
  - After gnt[i], req[i] and operands are don't-care; the operation completes and rsp_valid[i] is still issued.
  - A requester that keeps req[i] high across rsp_valid[i] is re-arbitrated with lowest priority.
- Simultaneous requests: the winner is the nearest index at or after rr_ptr; the losers are not granted and must keep req high.
- Starvation bound: any held request is granted within NREQ operations.
- Multiplier protocol:
  - mult_done is treated as a level qualifier; only its first high cycle in WAIT is used.
  - A mult_done seen in IDLE or RESP is ignored.
- Operands and results are forwarded unmodified; no width conversion and no sign interpretation.

Optional Feature:
- Macro: MULT_SHARE_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT+1)) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no mult_done: rsp_valid[idx]<=1, rsp_err<=1, rsp_product<=0, rsp_sign<=0, go RESP.
  - The multiplier is not reset; a late mult_done is ignored.
- Not defined: no counter; WAIT waits indefinitely; rsp_err is constant 0.

Test Plan:
- Bench setup: multiplier model asserts mult_done 6 cycles after mult_start and returns the unsigned product with sign=0.
- Reset: rst=1 for 2 cycles with req=2'b11 → all outputs 0, busy=0; first grant after rst drops goes to requester 0.
- Single request: req0 with multiplier 4'b0111, multiplicand 4'b1100 → gnt[0] and mult_start 1 cycle later with mult_multiplier=4'h7, mult_multiplicand=4'hC; rsp_valid[0] with rsp_product=8'h54 one cycle after mult_done; rsp_valid[1] never asserted.
- Contention: req=2'b11 held, req0 ops 7×15, req1 ops 10×5 → results in order req0 then req1: rsp_product=8'h69, then 8'h32; third grant goes to req0 again (fair alternation).
- Reset mid-operation: assert rst in WAIT before mult_done → no rsp_valid; state IDLE; rr_ptr=0; mult_done arriving after reset is ignored.
- Timeout (macro defined, TIMEOUT=10, model never asserts done): rsp_valid[idx] with rsp_err=1, rsp_product=8'h00 exactly 10 WAIT cycles after RUN. Without the macro, busy stays high and rsp_err stays 0.
- Request drop: req1 deasserted the cycle after gnt[1] with operands changed to 4'hF×4'hF → mult operands unchanged; rsp_valid[1] still issued with the original product.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between NREQ requesters.
// Optional watchdog on mult_done: define MULT_SHARE_ARBITER_TIMEOUT_EN.
module mult_share_arbiter #(
    parameter int DW      = 4,
    parameter int DW_2    = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_multiplier,
    input  logic [NREQ*DW-1:0]   req_multiplicand,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_sign,
    output logic [DW_2-1:0]      rsp_product,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mult_start,
    output logic [DW-1:0]        mult_multiplier,
    output logic [DW-1:0]        mult_multiplicand,
    input  logic                 mult_done,
    input  logic                 mult_sign,
    input  logic [DW_2-1:0]      mult_product
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    logic          found;
    logic          grant;
    logic          take_done;
    logic          take_tmo;

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : rr_select
        int unsigned pos;
        found = 1'b0;
        sel   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < int'(NREQ); k++) begin
            pos = (32'(rr_ptr) + k) % 32'(NREQ);
            if (!found && req[IW'(pos)]) begin
                found = 1'b1;
                sel   = IW'(pos);
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        take_done = 1'b0;
        take_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN:  state_n = WAIT;
            WAIT: begin
                if (mult_done) begin
                    take_done = 1'b1;
                    state_n   = RESP;
                end
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
                else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    take_tmo = 1'b1;
                    state_n  = RESP;
                end
`endif
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr            <= '0;
            idx               <= '0;
            gnt               <= '0;
            mult_start        <= 1'b0;
            mult_multiplier   <= '0;
            mult_multiplicand <= '0;
            rsp_valid         <= '0;
            rsp_sign          <= 1'b0;
            rsp_product       <= '0;
            rsp_err           <= 1'b0;
            busy              <= 1'b0;
        end else begin
            busy       <= (state_n != IDLE);
            gnt        <= grant ? (NREQ'(1) << sel) : '0;
            mult_start <= grant;
            if (grant) begin
                idx               <= sel;
                mult_multiplier   <= req_multiplier[sel*DW +: DW];
                mult_multiplicand <= req_multiplicand[sel*DW +: DW];
            end
            rsp_valid <= (take_done || take_tmo) ? (NREQ'(1) << idx) : '0;
            if (take_done) begin
                rsp_sign    <= mult_sign;
                rsp_product <= mult_product;
                rsp_err     <= 1'b0;
            end
            if (take_tmo) begin
                rsp_sign    <= 1'b0;
                rsp_product <= '0;
                rsp_err     <= 1'b1;
            end
            // The winner just served drops to lowest priority.
            if (state == RESP)
                rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)                tmo_cnt <= '0;
        else if (state == RUN)  tmo_cnt <= '0;
        else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a fixed-latency multiplier model.
// Timeout scenario follows MULT_SHARE_ARBITER_TIMEOUT_EN.
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] req_multiplier, req_multiplicand;
    logic [1:0] gnt, rsp_valid;
    logic       rsp_sign, rsp_err, busy, mult_start;
    logic [7:0] rsp_product;
    logic [3:0] mult_multiplier, mult_multiplicand;
    logic       mult_done    = 1'b0;
    logic       mult_sign    = 1'b0;
    logic [7:0] mult_product = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt0  = 0;
    int rv_cnt1  = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.DW(4), .DW_2(8), .NREQ(2), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sign(rsp_sign),
        .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
        .mult_start(mult_start), .mult_multiplier(mult_multiplier),
        .mult_multiplicand(mult_multiplicand), .mult_done(mult_done),
        .mult_sign(mult_sign), .mult_product(mult_product)
    );

    // Multiplier model: one-cycle done pulse 6 cycles after start, unsigned product.
    logic       model_en = 1'b1;
    int         m_cnt    = 0;
    logic [3:0] m_a      = 4'h0;
    logic [3:0] m_b      = 4'h0;
    always @(posedge clk) begin
        mult_done <= 1'b0;
        if (mult_start) begin
            m_cnt <= 6;
            m_a   <= mult_multiplier;
            m_b   <= mult_multiplicand;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            if (model_en) begin
                mult_done    <= 1'b1;
                mult_product <= {4'h0, m_a} * {4'h0, m_b};
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid[0]) rv_cnt0++;
        if (rsp_valid[1]) rv_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, output int cyc);
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 40) begin
            step();
            cyc++;
        end
        if (rsp_valid == 2'b00) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no rsp_valid expected one within 40 cycles", tag);
        end
    endtask

    task automatic wait_gnt(input string tag, output int cyc);
        cyc = 0;
        while (gnt == 2'b00 && cyc < 40) begin
            step();
            cyc++;
        end
        if (gnt == 2'b00) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no gnt expected one within 40 cycles", tag);
        end
    endtask

    logic [1:0] exp_gnt  [3] = '{2'b01, 2'b10, 2'b01};
    logic [7:0] exp_prod [3] = '{8'h69, 8'h32, 8'h69};

    initial begin
        int cyc;
        int c0, c1;

        // Reset with both requests pending
        rst = 1'b1;
        req = 2'b11;
        req_multiplier   = {4'h1, 4'h2};
        req_multiplicand = {4'h3, 4'h4};
        step(2);
        check("rst_gnt", gnt, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_start", mult_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_product", rsp_product, 8'h00);
        check("rst_err_sign", {rsp_err, rsp_sign}, 2'b00);
        check("rst_mult_ops", {mult_multiplier, mult_multiplicand}, 8'h00);
        rst = 1'b0;
        step();
        check("post_rst_gnt", gnt, 2'b01);
        check("post_rst_ops", {mult_multiplier, mult_multiplicand}, 8'h24);
        req = 2'b00;
        wait_rsp("post_rst_rsp", cyc);
        check("post_rst_rsp_valid", rsp_valid, 2'b01);
        check("post_rst_product", rsp_product, 8'h08);
        step(2);

        // Single request from requester 0 (rr_ptr now 1)
        c1 = rv_cnt1;
        req = 2'b01;
        req_multiplier   = {4'h0, 4'h7};
        req_multiplicand = {4'h0, 4'hC};
        step();
        check("single_gnt", gnt, 2'b01);
        check("single_start", mult_start, 1'b1);
        check("single_mplier", mult_multiplier, 4'h7);
        check("single_mcand", mult_multiplicand, 4'hC);
        check("single_busy_run", busy, 1'b1);
        req = 2'b00;
        step();
        check("single_gnt_drop", {gnt, mult_start}, 3'b000);
        cyc = 0;
        while (mult_done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check("single_no_early_rsp", rsp_valid, 2'b00);
        step();
        check("single_rsp_valid", rsp_valid, 2'b01);
        check("single_product", rsp_product, 8'h54);
        check("single_err_sign", {rsp_err, rsp_sign}, 2'b00);
        step();
        check("single_rsp_drop", rsp_valid, 2'b00);
        check("single_idle_busy", busy, 1'b0);
        check("single_product_hold", rsp_product, 8'h54);
        check("single_no_rsp1", rv_cnt1 - c1, 0);

        // Contention with both requests held
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 2'b11;
        req_multiplier   = {4'hA, 4'h7};
        req_multiplicand = {4'h5, 4'hF};
        for (int i = 0; i < 3; i++) begin
            wait_gnt("cont_gnt_wait", cyc);
            check("cont_gnt", gnt, exp_gnt[i]);
            if (i > 0) check("cont_spacing", cyc, 2);
            wait_rsp("cont_rsp_wait", cyc);
            check("cont_rsp_valid", rsp_valid, exp_gnt[i]);
            check("cont_product", rsp_product, exp_prod[i]);
        end
        req = 2'b00;
        step(2);

        // Reset while waiting for mult_done (rr_ptr is 1 here)
        req = 2'b10;
        req_multiplier   = {4'h3, 4'h0};
        req_multiplicand = {4'h3, 4'h0};
        step();
        check("midrst_gnt", gnt, 2'b10);
        req = 2'b00;
        step(3);
        check("midrst_busy_wait", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_outs", {gnt, rsp_valid, mult_start}, 5'b00000);
        c0 = rv_cnt0;
        c1 = rv_cnt1;
        step(12);
        check("midrst_no_rsp", (rv_cnt0 - c0) + (rv_cnt1 - c1), 0);
        check("midrst_still_idle", busy, 1'b0);
        req = 2'b11;
        step();
        check("midrst_rr_ptr_zero", gnt, 2'b01);
        req = 2'b00;
        wait_rsp("midrst_rsp_wait", cyc);
        step(2);

        // Request dropped with operands changed after grant (rr_ptr 1)
        req = 2'b10;
        req_multiplier   = {4'h4, 4'h0};
        req_multiplicand = {4'h6, 4'h0};
        step();
        check("drop_gnt", gnt, 2'b10);
        req = 2'b00;
        req_multiplier   = 8'hFF;
        req_multiplicand = 8'hFF;
        step();
        check("drop_ops_held", {mult_multiplier, mult_multiplicand}, 8'h46);
        wait_rsp("drop_rsp_wait", cyc);
        check("drop_rsp_valid", rsp_valid, 2'b10);
        check("drop_product", rsp_product, 8'h18);
        step();
        check("drop_ops_after_rsp", {mult_multiplier, mult_multiplicand}, 8'h46);

        // Multiplier never completes
        model_en = 1'b0;
        c0 = rv_cnt0;
        req = 2'b01;
        step();
        check("tmo_gnt", gnt, 2'b01);
        req = 2'b00;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
        wait_rsp("tmo_rsp_wait", cyc);
        check("tmo_latency", cyc, 11);
        check("tmo_rsp_valid", rsp_valid, 2'b01);
        check("tmo_err", rsp_err, 1'b1);
        check("tmo_product", rsp_product, 8'h00);
        step();
        check("tmo_idle", busy, 1'b0);
        check("tmo_err_hold", rsp_err, 1'b1);
`else
        step(30);
        check("notmo_busy", busy, 1'b1);
        check("notmo_err", rsp_err, 1'b0);
        check("notmo_no_rsp", rv_cnt0 - c0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
